// File: rtl/ntt_pkg.sv
// Shared constants for the NTT address path: conf command codes, the
// done_flag codes the address FSM reports per pass, and default pass lengths.
package ntt_pkg;

    localparam int CNT_W = 10;

    localparam logic [3:0] CONF_IDLE         = 4'd0;
    localparam logic [3:0] CONF_R2_NTT       = 4'd1;
    localparam logic [3:0] CONF_R4_NTT       = 4'd2;
    localparam logic [3:0] CONF_DONE_R2_NTT  = 4'd3;
    localparam logic [3:0] CONF_DONE_R4_NTT  = 4'd4;
    localparam logic [3:0] CONF_R4_INTT      = 4'd5;
    localparam logic [3:0] CONF_R2_INTT      = 4'd6;
    localparam logic [3:0] CONF_DONE_R2_INTT = 4'd7;
    localparam logic [3:0] CONF_DONE_R4_INTT = 4'd8;

    localparam logic [2:0] DF_R2_NTT  = 3'b001;
    localparam logic [2:0] DF_R4_NTT  = 3'b010;
    localparam logic [2:0] DF_R2_INTT = 3'b100;
    localparam logic [2:0] DF_R4_INTT = 3'b011;

    localparam int unsigned DEF_R2_CYCLES = 128;
    localparam int unsigned DEF_R4_CYCLES = 512;
    localparam int unsigned DEF_DRAIN_R2  = 8;
    localparam int unsigned DEF_DRAIN_R4  = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P1_DRAIN,
        S_P2,
        S_P2_DRAIN
    } seq_state_t;

    // Counter preload for a phase of 'len' cycles (counts len-1 down to 0).
    function automatic logic [CNT_W-1:0] lenToLoad(input int unsigned len);
        return CNT_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times each sequencer phase; o_tc marks the
// last cycle of the phase.
module phase_counter
    import ntt_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Load on a phase change, otherwise count down and rest at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/ntt_conf_sequencer.sv
// Drives the address FSM's conf bus through the two-pass NTT/INTT schedule,
// holds DONE codes while the write pipeline drains, and checks done_flag at
// the end of each pass.
module ntt_conf_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned R2_CYCLES = DEF_R2_CYCLES,
    parameter int unsigned R4_CYCLES = DEF_R4_CYCLES,
    parameter int unsigned DRAIN_R2  = DEF_DRAIN_R2,
    parameter int unsigned DRAIN_R4  = DEF_DRAIN_R4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mode,
    input  logic [2:0] i_done_flag,
    output logic [3:0] o_conf,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    seq_state_t       r_state;
    logic             r_mode;
    logic             r_first;
    logic [3:0]       r_conf;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    seq_state_t       w_nextState;
    logic             w_accept;
    logic             w_nextMode;
    logic [3:0]       w_nextConf;
    logic [CNT_W-1:0] w_loadVal;
    logic             w_load;
    logic             w_tc;
    logic             w_checkCycle;
    logic [2:0]       w_expFlag;

    phase_counter u_phase_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_loadVal),
        .o_tc       (w_tc)
    );

    // Next-state selection plus the conf code and length of the phase being entered.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && i_start;
        w_nextState = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_nextState = S_P1;
            S_P1:       if (w_tc)    w_nextState = S_P1_DRAIN;
            S_P1_DRAIN: if (w_tc)    w_nextState = S_P2;
            S_P2:       if (w_tc)    w_nextState = S_P2_DRAIN;
            S_P2_DRAIN: if (w_tc)    w_nextState = S_IDLE;
            default:                 w_nextState = S_IDLE;
        endcase

        w_nextMode = w_accept ? i_mode : r_mode;
        w_load     = (w_nextState != r_state);

        w_nextConf = CONF_IDLE;
        w_loadVal  = '0;
        case (w_nextState)
            S_P1: begin
                w_nextConf = w_nextMode ? CONF_R2_INTT : CONF_R4_NTT;
                w_loadVal  = w_nextMode ? lenToLoad(R2_CYCLES) : lenToLoad(R4_CYCLES);
            end
            S_P1_DRAIN: begin
                w_nextConf = w_nextMode ? CONF_DONE_R2_INTT : CONF_DONE_R4_NTT;
                w_loadVal  = w_nextMode ? lenToLoad(DRAIN_R2) : lenToLoad(DRAIN_R4);
            end
            S_P2: begin
                w_nextConf = w_nextMode ? CONF_R4_INTT : CONF_R2_NTT;
                w_loadVal  = w_nextMode ? lenToLoad(R4_CYCLES) : lenToLoad(R2_CYCLES);
            end
            S_P2_DRAIN: begin
                w_nextConf = w_nextMode ? CONF_DONE_R4_INTT : CONF_DONE_R2_NTT;
                w_loadVal  = w_nextMode ? lenToLoad(DRAIN_R4) : lenToLoad(DRAIN_R2);
            end
            default: begin
                w_nextConf = CONF_IDLE;
                w_loadVal  = '0;
            end
        endcase

        // The address FSM lags conf by one register, so its final compute
        // cycle lands in the first cycle of each drain phase.
        w_checkCycle = r_first && ((r_state == S_P1_DRAIN) || (r_state == S_P2_DRAIN));
        if (r_state == S_P1_DRAIN) begin
            w_expFlag = r_mode ? DF_R2_INTT : DF_R4_NTT;
        end else begin
            w_expFlag = r_mode ? DF_R4_INTT : DF_R2_NTT;
        end
    end

    // Sequencer state and registered host/address-FSM outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_first <= 1'b0;
            r_conf  <= CONF_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_mode  <= w_nextMode;
            r_first <= w_load;
            r_conf  <= w_nextConf;
            r_busy  <= (w_nextState != S_IDLE);
            r_done  <= (r_state == S_P2_DRAIN) && (w_nextState == S_IDLE);
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_checkCycle && (i_done_flag != w_expFlag)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_conf = r_conf;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule
